// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - three-byte UART command frame controller with link health tracking
// Validates SYNC/CMD/CHK frames, pulses accepted commands or rejections, and runs byte/link watchdogs.
module uart_cmd_ctrl #(
   parameter int unsigned NUM_FLOORS   = 8,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned BYTE_TIMEOUT = 200000,
   parameter int unsigned LINK_TIMEOUT = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       cmd_valid,
   output logic [1:0] cmd_type,
   output logic [3:0] cmd_floor,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic [7:0] err_count,
   output logic       link_alive
);

   typedef enum logic [1:0] {IDLE, WAIT_CMD, WAIT_CHK} state_t;

   state_t      state_q;
   logic [7:0]  cmd_q;
   logic [31:0] timer_q;
   logic [31:0] wd_q;
   logic        cmd_valid_q;
   logic [1:0]  cmd_type_q;
   logic [3:0]  cmd_floor_q;
   logic        frame_err_q;
   logic [1:0]  err_code_q;
   logic [7:0]  err_count_q;

   logic        chk_ok;
   logic        is_floor_cmd;
   logic        cmd_ok;
   logic        timeout;
   logic [7:0]  err_count_d;
   logic [1:0]  cmd_type_d;
   logic [3:0]  cmd_floor_d;

   // Frame evaluation is done against the latched CMD and the CHK byte currently on rx_data.
   always_comb begin
      chk_ok       = (rx_data == ~cmd_q);
      is_floor_cmd = (cmd_q[7:4] == 4'd1) || (cmd_q[7:4] == 4'd2);
      cmd_ok       = (cmd_q[7:4] >= 4'd1) && (cmd_q[7:4] <= 4'd4) &&
                     (!is_floor_cmd || ({28'd0, cmd_q[3:0]} < NUM_FLOORS));
      cmd_type_d   = cmd_q[5:4] - 2'd1;
      cmd_floor_d  = is_floor_cmd ? cmd_q[3:0] : 4'd0;
      timeout      = (timer_q == BYTE_TIMEOUT);
      err_count_d  = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_q       <= 8'd0;
         timer_q     <= 32'd0;
         wd_q        <= 32'd0;
         cmd_valid_q <= 1'b0;
         cmd_type_q  <= 2'd0;
         cmd_floor_q <= 4'd0;
         frame_err_q <= 1'b0;
         err_code_q  <= 2'd0;
         err_count_q <= 8'd0;
      end else begin
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         if (wd_q != 32'd0) begin
            wd_q <= wd_q - 32'd1;
         end
         case (state_q)
            IDLE: begin
               timer_q <= 32'd0;
               if (rx_valid && (rx_data == SYNC_BYTE)) begin
                  state_q <= WAIT_CMD;
               end
            end
            WAIT_CMD: begin
               if (rx_valid) begin
                  cmd_q   <= rx_data;
                  timer_q <= 32'd0;
                  state_q <= WAIT_CHK;
               end else if (timeout) begin
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'd3;
                  err_count_q <= err_count_d;
                  timer_q     <= 32'd0;
                  state_q     <= IDLE;
               end else begin
                  timer_q <= timer_q + 32'd1;
               end
            end
            WAIT_CHK: begin
               if (rx_valid) begin
                  timer_q <= 32'd0;
                  state_q <= IDLE;
                  if (!chk_ok || !cmd_ok) begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= chk_ok ? 2'd2 : 2'd1;
                     err_count_q <= err_count_d;
                  end else begin
                     cmd_valid_q <= 1'b1;
                     cmd_type_q  <= cmd_type_d;
                     cmd_floor_q <= cmd_floor_d;
                     wd_q        <= LINK_TIMEOUT;
                  end
               end else if (timeout) begin
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'd3;
                  err_count_q <= err_count_d;
                  timer_q     <= 32'd0;
                  state_q     <= IDLE;
               end else begin
                  timer_q <= timer_q + 32'd1;
               end
            end
            default: begin
               timer_q <= 32'd0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_type   = cmd_type_q;
   assign cmd_floor  = cmd_floor_q;
   assign frame_err  = frame_err_q;
   assign err_code   = err_code_q;
   assign err_count  = err_count_q;
   assign link_alive = (wd_q != 32'd0);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - table-driven bench for uart_cmd_ctrl
// Frame vectors with hand-computed outputs, plus timed sequences for timeouts, reset and watchdog.
module tb_uart_cmd_ctrl;

   localparam int unsigned NF = 8;
   localparam int unsigned BT = 100;
   localparam int unsigned LT = 1000;
   localparam int          NV = 13;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       cmd_valid;
   logic [1:0] cmd_type;
   logic [3:0] cmd_floor;
   logic       frame_err;
   logic [1:0] err_code;
   logic [7:0] err_count;
   logic       link_alive;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
      logic       v;
      logic       e;
      logic [1:0] t;
      logic [3:0] f;
      logic [1:0] c;
      logic [7:0] n;
      logic       a;
   } vec_t;

   vec_t vecs [NV];

   uart_cmd_ctrl #(
      .NUM_FLOORS  (NF),
      .SYNC_BYTE   (8'hA5),
      .BYTE_TIMEOUT(BT),
      .LINK_TIMEOUT(LT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .cmd_valid (cmd_valid),
      .cmd_type  (cmd_type),
      .cmd_floor (cmd_floor),
      .frame_err (frame_err),
      .err_code  (err_code),
      .err_count (err_count),
      .link_alive(link_alive)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      idle_cycle();
   endtask

   function automatic logic [18:0] outs();
      return {cmd_valid, frame_err, cmd_type, cmd_floor, err_code, err_count, link_alive};
   endfunction

   initial begin
      int first;
      logic [18:0] exp_o;

      //            b0     b1     b2     v  e  t     f     c     n      a
      vecs[0]  = '{8'hA5, 8'h13, 8'hEC, 1'b1, 1'b0, 2'd0, 4'd3, 2'd0, 8'd0, 1'b1};
      vecs[1]  = '{8'hA5, 8'h13, 8'h00, 1'b0, 1'b1, 2'd0, 4'd3, 2'd1, 8'd1, 1'b1};
      vecs[2]  = '{8'hA5, 8'h32, 8'hCD, 1'b1, 1'b0, 2'd2, 4'd0, 2'd1, 8'd1, 1'b1};
      vecs[3]  = '{8'hA5, 8'h50, 8'hAF, 1'b0, 1'b1, 2'd2, 4'd0, 2'd2, 8'd2, 1'b1};
      vecs[4]  = '{8'hA5, 8'h19, 8'hE6, 1'b0, 1'b1, 2'd2, 4'd0, 2'd2, 8'd3, 1'b1};
      vecs[5]  = '{8'hA5, 8'h27, 8'hD8, 1'b1, 1'b0, 2'd1, 4'd7, 2'd2, 8'd3, 1'b1};
      vecs[6]  = '{8'hA5, 8'h28, 8'hD7, 1'b0, 1'b1, 2'd1, 4'd7, 2'd2, 8'd4, 1'b1};
      vecs[7]  = '{8'hA5, 8'h4F, 8'hB0, 1'b1, 1'b0, 2'd3, 4'd0, 2'd2, 8'd4, 1'b1};
      vecs[8]  = '{8'hA5, 8'hA5, 8'h5A, 1'b0, 1'b1, 2'd3, 4'd0, 2'd2, 8'd5, 1'b1};
      vecs[9]  = '{8'hA5, 8'h00, 8'hFF, 1'b0, 1'b1, 2'd3, 4'd0, 2'd2, 8'd6, 1'b1};
      vecs[10] = '{8'hA5, 8'h10, 8'hEF, 1'b1, 1'b0, 2'd0, 4'd0, 2'd2, 8'd6, 1'b1};
      vecs[11] = '{8'hA5, 8'h37, 8'hC8, 1'b1, 1'b0, 2'd2, 4'd0, 2'd2, 8'd6, 1'b1};
      vecs[12] = '{8'hA5, 8'h50, 8'h00, 1'b0, 1'b1, 2'd2, 4'd0, 2'd1, 8'd7, 1'b1};

      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_state", 32'(outs()), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2);
         exp_o = {vecs[i].v, vecs[i].e, vecs[i].t, vecs[i].f, vecs[i].c, vecs[i].n, vecs[i].a};
         chk($sformatf("vec%0d", i), 32'(outs()), 32'(exp_o));
         @(negedge clk);
         chk($sformatf("vec%0d_pulse_end", i), 32'({cmd_valid, frame_err}), 32'd0);
      end

      // Noise in IDLE is silently dropped
      first = 0;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h13);
      for (int k = 0; k < 4; k++) begin
         idle_cycle();
         if (cmd_valid || frame_err) first = 1;
      end
      chk("noise_no_pulse", 32'(first), 32'd0);
      chk("noise_count", 32'(err_count), 32'd7);
      send_frame(8'hA5, 8'h13, 8'hEC);
      chk("after_noise_frame", 32'({cmd_valid, cmd_type, cmd_floor}), 32'({1'b1, 2'd0, 4'd3}));

      // Timeout: frame_err exactly BT+1 cycles after the SYNC byte
      send_byte(8'hA5);
      idle_cycle();
      first = 0;
      for (int k = 1; k <= int'(BT) + 10 && first == 0; k++) begin
         @(negedge clk);
         if (frame_err) first = k;
      end
      chk("timeout_latency", 32'(first), 32'(BT + 1));
      chk("timeout_code", 32'(err_code), 32'd3);
      chk("timeout_count", 32'(err_count), 32'd8);

      // CMD byte landing on the expiry cycle wins over the timeout
      send_byte(8'hA5);
      idle_cycle();
      repeat (BT - 1) @(negedge clk);
      send_byte(8'h27);
      send_byte(8'hD8);
      idle_cycle();
      chk("expiry_byte_wins", 32'({cmd_valid, frame_err, cmd_type, cmd_floor}),
          32'({1'b1, 1'b0, 2'd1, 4'd7}));
      chk("expiry_count", 32'(err_count), 32'd8);

      // Reset between SYNC and CMD
      send_byte(8'hA5);
      @(negedge clk);
      rx_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_frame", 32'({frame_err, err_count, link_alive}), 32'd0);
      send_frame(8'h13, 8'hEC, 8'h00);
      chk("rst_back_to_idle", 32'({cmd_valid, frame_err, err_count}), 32'd0);

      // Watchdog falls exactly LT cycles after cmd_valid
      send_frame(8'hA5, 8'h13, 8'hEC);
      chk("wd_alive", 32'({cmd_valid, link_alive}), 32'b11);
      first = 0;
      for (int k = 1; k <= int'(LT) + 10 && first == 0; k++) begin
         @(negedge clk);
         if (!link_alive) first = k;
      end
      chk("wd_fall_latency", 32'(first), 32'(LT));

      // Good frame accepted on the expiry cycle keeps the link alive
      send_frame(8'hA5, 8'h32, 8'hCD);
      chk("wd_realive", 32'({cmd_valid, link_alive}), 32'b11);
      repeat (LT - 4) @(negedge clk);
      send_frame(8'hA5, 8'h13, 8'hEC);
      chk("wd_expiry_reload", 32'({cmd_valid, link_alive}), 32'b11);
      @(negedge clk);
      chk("wd_still_alive", 32'(link_alive), 32'd1);

      // Error counter saturation
      for (int i = 0; i < 300; i++) begin
         send_byte(8'hA5);
         send_byte(8'h13);
         send_byte(8'h00);
      end
      idle_cycle();
      chk("sat_count", 32'(err_count), 32'd255);
      chk("sat_code", 32'({frame_err, err_code}), 32'({1'b1, 2'd1}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Frame controller sitting directly behind the 8-N-1 UART receiver on the elevator panel FPGA. Consumes the receiver's byte/valid stream from the gesture-recognition host, assembles fixed three-byte command frames, and validates sync, checksum, command type and floor range. Emits one-cycle command pulses to the floor-request logic. Also tracks link health with an inter-byte timeout, a link-alive watchdog and a saturating error counter.

## Interface
- NUM_FLOORS, 8: number of served floors; legal floor index range is 0..NUM_FLOORS-1, maximum 16.
- SYNC_BYTE, 8'hA5: frame start marker.
- BYTE_TIMEOUT, 200000: maximum clk cycles allowed between consecutive bytes of one frame (2 ms at 100 MHz).
- LINK_TIMEOUT, 100000000: clk cycles without a good frame before the link is declared dead (1 s).
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte; sampled only when rx_valid = 1.
- rx_valid  input  1  single-cycle strobe, one per byte.
- cmd_valid  output  1  one-cycle pulse when a good frame is accepted.
- cmd_type  output  2  0 = call, 1 = cancel, 2 = door open, 3 = door close; held until the next accepted frame.
- cmd_floor  output  4  floor index for call/cancel; 0 for door commands; held like cmd_type.
- frame_err  output  1  one-cycle pulse on a rejected frame.
- err_code  output  2  1 = checksum, 2 = illegal command/floor, 3 = timeout; held until the next frame_err.
- err_count  output  8  total rejected frames, saturates at 255.
- link_alive  output  1  high while a good frame has been seen within LINK_TIMEOUT cycles.

## Operation
- Frame format is SYNC_BYTE, CMD, CHK.
  - CMD[7:4] type code: 1 = call, 2 = cancel, 3 = open, 4 = close.
  - CMD[3:0] floor.
  - CHK must equal bitwise NOT of CMD.
- FSM states: IDLE, WAIT_CMD, WAIT_CHK.
- IDLE:
  - rx_valid with rx_data = SYNC_BYTE -> WAIT_CMD.
  - Any other byte is discarded silently: no error, no count.
- WAIT_CMD:
  - rx_valid latches the byte as CMD -> WAIT_CHK.
  - This includes a byte equal to SYNC_BYTE; there is no resynchronisation inside a frame.
- WAIT_CHK:
  - rx_valid -> IDLE, then evaluate the frame in this priority order:
    1. CHK != ~CMD: reject, code 1.
    2. Type code not in 1..4: reject, code 2.
    3. Type 1 or 2 with floor >= NUM_FLOORS: reject, code 2.
    4. Otherwise accept. cmd_type = type-1.
  - On accept, cmd_floor = CMD[3:0] for types 1/2 and 0 for types 3/4.
  - For open/close, CMD[3:0] is ignored and not range-checked.
- Inter-byte timer:
  - Cleared on every rx_valid.
  - Counts only in WAIT_CMD/WAIT_CHK.
  - On reaching BYTE_TIMEOUT: reject with code 3 -> IDLE.
  - The timer is held at 0 in IDLE.
- Rejection effects: frame_err pulses, err_code updates, err_count increments, saturating at 255.
- Link watchdog:
  - Reloaded to LINK_TIMEOUT on every accepted frame.
  - Decrements otherwise.
  - link_alive = (watchdog != 0).
  - Rejected frames never reload the watchdog.
- Arithmetic: timers are 32-bit unsigned; counter widths are not derived from parameters.

## Timing
- Reset values: all outputs 0, FSM = IDLE, timers 0. link_alive = 0 until the first good frame.
- Latency: cmd_valid or frame_err is asserted in the cycle after the rx_valid carrying CHK. cmd_type, cmd_floor and err_code change in that same cycle.
- Timeout: frame_err with code 3 is asserted in the cycle after the timer equals BYTE_TIMEOUT, i.e. BYTE_TIMEOUT+1 cycles after the last byte.
- Simultaneous rx_valid and timeout expiry in the same cycle: the byte wins. It is processed normally, the timer clears, and no timeout error is raised.
- cmd_valid and frame_err are never high in the same cycle. At most one of them pulses per frame.
- Back-to-back bytes: rx_valid on consecutive cycles must be handled, with no stall and no dropped byte.
- rst asserted mid-frame: next cycle is IDLE, the partial frame is discarded, and no error is reported. err_count and link_alive clear.
- Watchdog: link_alive falls exactly LINK_TIMEOUT cycles after the cmd_valid cycle when no further good frame arrives. A good frame arriving on the expiry cycle keeps link_alive high.

## Test plan
- Good call frame: A5, 13, EC (NUM_FLOORS = 8) -> one cmd_valid; cmd_type = 0, cmd_floor = 3; link_alive rises; err_count = 0.
- Checksum error: A5, 13, 00 -> frame_err with err_code = 1, err_count = 1, no cmd_valid. A following good frame A5, 32, CD gives cmd_type = 2, cmd_floor = 0.
- Illegal command and range: A5, 5x (type 5) -> code 2. A5, 19, E6 (call floor 9 >= 8) -> code 2. Checksums are valid in both cases; err_count = 2.
- Timeout: A5 then silence -> frame_err with code 3 at BYTE_TIMEOUT+1 cycles. Repeat with a CMD byte landing on the exact expiry cycle -> no error, and the frame completes normally.
- Noise, resync and reset: bytes 00, FF, 13 in IDLE -> no outputs. A5, A5, 5A -> CMD = A5 -> type 0xA illegal, code 2. rst between SYNC and CMD -> IDLE with no error.
- Saturation and watchdog, with reduced LINK_TIMEOUT = 1000:
  - 300 bad-checksum frames -> err_count holds at 255.
  - One good frame then idle -> link_alive low exactly 1000 cycles after cmd_valid.
